pwm_preconditioner: RTL and testbench



---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_edge_calc.sv | 129 ++++++++++++
 rtl/pwm_preconditioner.sv | 154 +++++++++++++++
 tb/tb_pwm_preconditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types for the PWM preconditioner slice.
//   pwm_state_t : pass sequencer states (IDLE, RUN, DRAIN, COMMIT)
//   PIPE_DEPTH  : number of stages in the per-transducer edge pipeline
//   edge_t      : one transducer's committed edge pair {rise, fall}
// EDGE_W sizes edge_t and must match the WIDTH parameter of the users.
// -----------------------------------------------------------------------------
package pwm_pkg;

   parameter int EDGE_W = 13;

   localparam int PIPE_DEPTH = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      DRAIN  = 2'd2,
      COMMIT = 2'd3
   } pwm_state_t;

   typedef struct packed {
      logic [EDGE_W-1:0] rise;
      logic [EDGE_W-1:0] fall;
   } edge_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// -----------------------------------------------------------------------------
// pwm_edge_calc
// Three-stage pipeline turning one transducer's duty/phase into rise/fall edge
// times inside a carrier cycle of length 'cycle'. One transducer per clock.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset (valid bits only)
//   valid, idx          : issue strobe and transducer index
//   duty, phase         : raw operands, sampled in the issue cycle
//   cycle               : carrier period, held constant for a whole pass
//   edge_valid, edge_idx: result strobe and index (third stage, combinational)
//   rise, fall          : resulting edge times
// -----------------------------------------------------------------------------
module pwm_edge_calc
   import pwm_pkg::*;
#(
   parameter int WIDTH = 13,
   parameter int IDX_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid,
   input  logic [IDX_W-1:0] idx,
   input  logic [WIDTH-1:0] duty,
   input  logic [WIDTH-1:0] phase,
   input  logic [WIDTH-1:0] cycle,
   output logic             edge_valid,
   output logic [IDX_W-1:0] edge_idx,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);

   // Duty saturates at the carrier period.
   function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] d,
                                                   input logic [WIDTH-1:0] cyc);
      return (d > cyc) ? cyc : d;
   endfunction

   // Phase is known to be below 2*cycle, so one conditional subtract folds it.
   function automatic logic [WIDTH-1:0] fold_phase(input logic [WIDTH-1:0] ph,
                                                   input logic [WIDTH-1:0] cyc);
      return (ph < cyc) ? ph : ph - cyc;
   endfunction

   function automatic logic [WIDTH-1:0] wrap_rise(input logic signed [WIDTH:0] diff,
                                                  input logic [WIDTH-1:0]      cyc);
      logic signed [WIDTH:0] t;
      t = (diff < 0) ? diff + $signed({1'b0, cyc}) : diff;
      return t[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] wrap_fall(input logic [WIDTH:0]   sum,
                                                  input logic [WIDTH-1:0] cyc);
      logic [WIDTH:0] t;
      t = (sum >= {1'b0, cyc}) ? sum - {1'b0, cyc} : sum;
      return t[WIDTH-1:0];
   endfunction

   logic             vld_p0;
   logic [IDX_W-1:0] idx_p0;
   logic [WIDTH-1:0] d_p0;
   logic [WIDTH-1:0] ph_p0;
   logic [WIDTH-1:0] hlo_p0;
   logic [WIDTH-1:0] hhi_p0;

   logic             vld_p1;
   logic [IDX_W-1:0] idx_p1;
   logic [WIDTH-1:0] d_p1;
   logic [WIDTH-1:0] r_p1;
   logic [WIDTH-1:0] f_p1;

   logic [WIDTH-1:0]      d_s1;
   logic [WIDTH-1:0]      hlo_s1;
   logic signed [WIDTH:0] diff_s2;
   logic [WIDTH:0]        sum_s2;

   // ---- stage 1: operand preparation -> _p0 ----
   always_comb begin
      d_s1   = clamp_duty(duty, cycle);
      hlo_s1 = d_s1 >> 1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_p0 <= 1'b0;
      else        vld_p0 <= valid;
   end

   always_ff @(posedge clk) begin
      idx_p0 <= idx;
      d_p0   <= d_s1;
      ph_p0  <= fold_phase(phase, cycle);
      hlo_p0 <= hlo_s1;
      hhi_p0 <= d_s1 - hlo_s1;
   end

   // ---- stage 2: edge arithmetic with one guard bit -> _p1 ----
   always_comb begin
      diff_s2 = $signed({1'b0, ph_p0}) - $signed({1'b0, hlo_p0});
      sum_s2  = {1'b0, ph_p0} + {1'b0, hhi_p0};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) vld_p1 <= 1'b0;
      else        vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      idx_p1 <= idx_p0;
      d_p1   <= d_p0;
      r_p1   <= wrap_rise(diff_s2, cycle);
      f_p1   <= wrap_fall(sum_s2, cycle);
   end

   // ---- stage 3: special cases, result written by the caller ----
   always_comb begin
      rise = r_p1;
      fall = f_p1;
      if (d_p1 == '0) begin
         rise = '0;
         fall = '0;
      end else if (d_p1 == cycle) begin
         rise = '0;
         fall = cycle;
      end
   end

   assign edge_valid = vld_p1;
   assign edge_idx   = idx_p1;

endmodule

// File: rtl/pwm_preconditioner.sv
// -----------------------------------------------------------------------------
// pwm_preconditioner
// Converts per-transducer duty/phase into rise/fall edge times for the PWM
// generators. A START pass streams all DEPTH transducers through the edge
// pipeline into a shadow buffer, then copies the buffer to RISE/FALL in a
// single commit cycle so the generators never see a partial update.
// Ports:
//   CLK, RST_N    : clock, synchronous active-low reset
//   CYCLE         : carrier period, latched when a pass starts
//   START         : pass request (modulator DONE); ignored unless idle
//   DUTY, PHASE   : per-transducer operands, read live as each is issued
//   RISE, FALL    : committed edge times
//   BUSY          : pass in progress (RUN, DRAIN, COMMIT)
//   DONE          : high during the commit cycle
// Build option PWM_PRECONDITIONER_OVERRUN_EN adds OVERRUN (sticky flag for an
// ignored START, cleared by the next accepted one) and OVERRUN_CNT (saturating
// count of ignored STARTs).
// -----------------------------------------------------------------------------
module pwm_preconditioner
   import pwm_pkg::*;
#(
   parameter int WIDTH = 13,
   parameter int DEPTH = 249
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic [WIDTH-1:0] CYCLE,
   input  logic             START,
   input  logic [WIDTH-1:0] DUTY  [0:DEPTH-1],
   input  logic [WIDTH-1:0] PHASE [0:DEPTH-1],
   output logic [WIDTH-1:0] RISE  [0:DEPTH-1],
   output logic [WIDTH-1:0] FALL  [0:DEPTH-1],
   output logic             BUSY,
   output logic             DONE
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
   ,
   output logic             OVERRUN,
   output logic [15:0]      OVERRUN_CNT
`endif
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   pwm_state_t       state;
   pwm_state_t       state_nxt;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] cyc_r;
   logic             start_accept;

   logic             edge_valid;
   logic [IDX_W-1:0] edge_idx;
   logic [WIDTH-1:0] edge_rise;
   logic [WIDTH-1:0] edge_fall;

   edge_t            shadow [0:DEPTH-1];

   assign start_accept = (state == IDLE) && START;
   assign BUSY         = (state != IDLE);
   assign DONE         = (state == COMMIT);

   // Sequencer
   always_ff @(posedge CLK) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   // DRAIN ends when the last transducer reaches the shadow-write stage, so
   // its write and the transition into COMMIT land on the same edge.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (START) state_nxt = RUN;
         RUN:     if (idx == LAST_IDX) state_nxt = DRAIN;
         DRAIN:   if (edge_valid && (edge_idx == LAST_IDX)) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         idx <= '0;
      end else if (state == RUN) begin
         idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
         idx <= '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (start_accept) cyc_r <= CYCLE;
   end

   pwm_edge_calc #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_edge_calc (
      .clk        (CLK),
      .rst_n      (RST_N),
      .valid      (state == RUN),
      .idx        (idx),
      .duty       (DUTY[idx]),
      .phase      (PHASE[idx]),
      .cycle      (cyc_r),
      .edge_valid (edge_valid),
      .edge_idx   (edge_idx),
      .rise       (edge_rise),
      .fall       (edge_fall)
   );

   // Shadow buffer
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) shadow[i] <= '0;
      end else if (edge_valid) begin
         shadow[edge_idx] <= '{rise: edge_rise, fall: edge_fall};
      end
   end

   // Atomic commit to the generator-facing registers
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         for (int i = 0; i < DEPTH; i++) begin
            RISE[i] <= '0;
            FALL[i] <= '0;
         end
      end else if (state == COMMIT) begin
         for (int i = 0; i < DEPTH; i++) begin
            RISE[i] <= shadow[i].rise;
            FALL[i] <= shadow[i].fall;
         end
      end
   end

`ifdef PWM_PRECONDITIONER_OVERRUN_EN
   logic start_ignored;

   assign start_ignored = START && (state != IDLE);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         OVERRUN     <= 1'b0;
         OVERRUN_CNT <= '0;
      end else if (start_accept) begin
         OVERRUN <= 1'b0;
      end else if (start_ignored) begin
         OVERRUN <= 1'b1;
         if (OVERRUN_CNT != 16'hFFFF) OVERRUN_CNT <= OVERRUN_CNT + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pwm_preconditioner.sv
module tb_pwm_preconditioner;

   localparam int W = 13;
   localparam int N = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] cycle;
   logic         start;
   logic [W-1:0] duty  [0:N-1];
   logic [W-1:0] phase [0:N-1];
   logic [W-1:0] rise  [0:N-1];
   logic [W-1:0] fall  [0:N-1];
   logic         busy;
   logic         done;
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
   logic         overrun;
   logic [15:0]  overrun_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pwm_preconditioner #(
      .WIDTH (W),
      .DEPTH (N)
   ) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .CYCLE       (cycle),
      .START       (start),
      .DUTY        (duty),
      .PHASE       (phase),
      .RISE        (rise),
      .FALL        (fall),
      .BUSY        (busy),
      .DONE        (done)
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
      ,
      .OVERRUN     (overrun),
      .OVERRUN_CNT (overrun_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_all(input int d, input int p);
      for (int i = 0; i < N; i++) begin
         duty[i]  = W'(d);
         phase[i] = W'(p);
      end
   endtask

   task automatic set_one(input int i, input int d, input int p);
      duty[i]  = W'(d);
      phase[i] = W'(p);
   endtask

   task automatic check_edge(input string tag, input int i, input int r, input int f);
      check($sformatf("%s_rise%0d", tag, i), 32'(rise[i]), r);
      check($sformatf("%s_fall%0d", tag, i), 32'(fall[i]), f);
   endtask

   // Pulses START, optionally changes CYCLE right after it was latched, waits
   // for DONE (bounded) and returns one cycle after the commit edge.
   task automatic run_pass(input int cyc_after, output int lat);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycle = W'(cyc_after);
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int lat;
      int ndone;

      rst_n = 1'b0;
      start = 1'b0;
      cycle = '0;
      set_all(0, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      for (int i = 0; i < N; i++) check_edge("rst", i, 0, 0);
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
      check("rst_ovr", 32'(overrun), 0);
      check("rst_ovr_cnt", 32'(overrun_cnt), 0);
`endif

      // Basic pass: latency and outputs held until commit
      cycle = 13'd4096;
      set_all(2048, 1024);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("t1_busy", 32'(busy), 1);
      lat = 1;
      while (!done && lat < 40) begin
         for (int i = 0; i < N; i++) check_edge("t1_hold", i, 0, 0);
         @(posedge clk); #1;
         lat++;
      end
      check("t1_latency", lat, 7);
      for (int i = 0; i < N; i++) check_edge("t1_hold_done", i, 0, 0);
      @(posedge clk); #1;
      check("t1_busy_after", 32'(busy), 0);
      check("t1_done_after", 32'(done), 0);
      for (int i = 0; i < N; i++) check_edge("t1", i, 0, 2048);

      // Wrap-around and special duties
      set_one(0, 1000, 100);
      set_one(1, 1001, 4000);
      set_one(2, 0, 500);
      set_one(3, 4096, 7);
      run_pass(4096, lat);
      check("t2a_latency", lat, 7);
      check_edge("t2a", 0, 3696, 600);
      check_edge("t2a", 1, 3500, 405);
      check_edge("t2a", 2, 0, 0);
      check_edge("t2a", 3, 0, 4096);

      set_one(0, 5000, 0);
      set_one(1, 200, 4196);
      set_one(2, 2, 0);
      set_one(3, 4095, 4095);
      run_pass(4096, lat);
      check_edge("t2b", 0, 0, 4096);
      check_edge("t2b", 1, 0, 200);
      check_edge("t2b", 2, 4095, 1);
      check_edge("t2b", 3, 2048, 2047);

      // STARTs while busy and in the commit cycle are ignored
      set_all(100, 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0;
      for (int c = 1; c < 30; c++) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (done) begin
            ndone++;
            start = 1'b1;
         end
         if (c == 1) start = 1'b1;
      end
      start = 1'b0;
      check("t3_done_count", ndone, 1);
      check("t3_busy", 32'(busy), 0);
      for (int i = 0; i < N; i++) check_edge("t3", i, 4046, 50);
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
      check("t3_ovr", 32'(overrun), 1);
      check("t3_ovr_cnt", 32'(overrun_cnt), 2);
`endif

      // CYCLE changed mid-pass: this pass keeps 4096, next uses 2000
      set_all(1000, 100);
      cycle = 13'd4096;
      run_pass(2000, lat);
      for (int i = 0; i < N; i++) check_edge("t5a", i, 3696, 600);
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
      check("t5_ovr_clr", 32'(overrun), 0);
      check("t5_ovr_cnt", 32'(overrun_cnt), 2);
`endif
      run_pass(2000, lat);
      for (int i = 0; i < N; i++) check_edge("t5b", i, 1600, 600);

      // Reset in the middle of RUN
      set_all(2048, 1024);
      cycle = 13'd4096;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("t4_busy", 32'(busy), 0);
      check("t4_done", 32'(done), 0);
      for (int i = 0; i < N; i++) check_edge("t4_rst", i, 0, 0);
`ifdef PWM_PRECONDITIONER_OVERRUN_EN
      check("t4_ovr", 32'(overrun), 0);
      check("t4_ovr_cnt", 32'(overrun_cnt), 0);
`endif
      ndone = 0;
      for (int c = 0; c < 15; c++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("t4_no_done", ndone, 0);
      check("t4_idle", 32'(busy), 0);
      run_pass(4096, lat);
      check("t4_latency", lat, 7);
      for (int i = 0; i < N; i++) check_edge("t4", i, 0, 2048);

      // Zero carrier period
      set_all(100, 5);
      cycle = '0;
      run_pass(0, lat);
      check("t6_latency", lat, 7);
      for (int i = 0; i < N; i++) check_edge("t6", i, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
